apu_share_arbiter: RTL and testbench
====================================

Name: apu_share_arbiter

Overview:
- Shares one APU accelerator between NUM_REQ core APU ports; sits between the cores' apu_* interfaces and the accelerator's request/response channel.
- Round-robin arbitration with a request lock held until grant.
- In-order outstanding-ID FIFO routes each accelerator result back to the issuing core.
- Response path registered: one cycle latency.

Parameters:
- NUM_REQ, 2, number of requesting cores (2..4).
- MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO (power of two, 2..16).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-core apu_req
- gnt_o  out  NUM_REQ  per-core apu_gnt
- operands_i  in  NUM_REQ x 3 x 32  per-core apu_operands
- op_i  in  NUM_REQ x 6  per-core apu_op
- flags_i  in  NUM_REQ x 15  per-core apu_flags
- rvalid_o  out  NUM_REQ  per-core apu_rvalid
- result_o  out  32  result, shared by all cores, qualified by rvalid_o
- rflags_o  out  6  response flags, shared, qualified by rvalid_o
- acc_req_o  out  1  request to accelerator
- acc_gnt_i  in  1  accelerator grant
- acc_operands_o  out  3x32  selected operands
- acc_op_o  out  6  selected op
- acc_flags_o  out  15  selected flags
- acc_rvalid_i  in  1  accelerator result valid
- acc_result_i  in  32  accelerator result
- acc_flags_i  in  6  accelerator response flags
- err_o  out  1  sticky protocol error
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  in-flight count

Behaviour:
Reset:
- gnt_o, rvalid_o, acc_req_o, err_o, outstanding_o all 0.
- result_o and rflags_o are 0.
- RR pointer is 0; FSM in IDLE; FIFO empty.

FSM states: IDLE, LOCKED.
- IDLE
  - full = (count == MAX_OUTSTANDING). If full, acc_req_o = 0.
  - Otherwise, select the first asserted req_i scanning from the RR pointer upward with wrap.
  - acc_req_o = 1 when any request is present; payload is muxed combinationally from the selected core.
  - If acc_gnt_i is 1 in the same cycle: issue; stay in IDLE.
  - If acc_gnt_i is 0: register the selected index; go to LOCKED.
- LOCKED
  - Selection is frozen to the registered index, even if a higher-priority core raises req.
  - acc_req_o = req_i[locked].
  - On acc_gnt_i, issue and return to IDLE.
  - If the core drops req_i[locked] without a grant (protocol violation): set err_o, return to IDLE, no issue.
- Issue (acc_req_o & acc_gnt_i)
  - gnt_o[sel] = 1 combinationally in the same cycle; all other gnt_o are 0.
  - Push sel into the FIFO.
  - RR pointer <= (sel+1) mod NUM_REQ.
- Response
  - On acc_rvalid_i with FIFO non-empty: pop the head ID.
  - Next cycle: rvalid_o[id] = 1 for exactly one cycle; result_o and rflags_o are registered copies of acc_result_i and acc_flags_i.
  - On acc_rvalid_i with FIFO empty: set err_o, drop the response, no rvalid_o.
  - result_o and rflags_o hold their last value when no response.
- Simultaneous issue and pop
  - count is unchanged; push and pop both take effect.
  - Full is evaluated on the registered count, so no issue while full, even if a pop occurs the same cycle. This keeps the gnt path free of rvalid.
- Pointers wrap modulo MAX_OUTSTANDING; count saturates only by construction (no push when full).
- err_o is sticky until reset.
- Reset mid-operation: FIFO is flushed and in-flight results are lost. The accelerator must be reset together with the arbiter.
- Responses are assumed in issue order (accelerator is in-order); no reordering.

Test Plan:
- Single core: core0 req with op=6'h05, acc_gnt_i same cycle → gnt_o=2'b01 in that cycle. acc_rvalid_i with result 32'hDEADBEEF two cycles later → rvalid_o=2'b01 one cycle after, result_o=32'hDEADBEEF, outstanding_o 1→0.
- Round-robin: both cores hold req with acc_gnt_i tied 1 → grants alternate 01,10,01,10. Four rvalid pulses route to 0,1,0,1 in order.
- Lock: core1 selected with acc_gnt_i=0 for 3 cycles while core0 raises req → acc_op_o stays core1's op. Grant on cycle 4 → gnt_o=2'b10, then core0 issues next.
- Full: MAX_OUTSTANDING=4 issues with no responses → acc_req_o=0 and outstanding_o=4. One rvalid arrives → acc_req_o=1 on the cycle after count drops to 3.
- Errors: acc_rvalid_i with empty FIFO → err_o=1, rvalid_o=0. Separately, a locked core drops req before grant → err_o=1, FSM returns to IDLE.
- Reset mid-flight: 2 outstanding, assert rst_ni=0 asynchronously → all outputs 0 immediately, outstanding_o=0 after release.

Source files
------------

// File: rtl/apu_share_arbiter.sv
// Round-robin share of one APU accelerator between NUM_REQ cores; in-order ID FIFO routes results back.
// Grant is combinational with the accelerator grant; responses are registered (1 cycle); no issue while the FIFO is full.
module apu_share_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  input  logic [NUM_REQ-1:0][2:0][31:0]        operands_i,
  input  logic [NUM_REQ-1:0][5:0]              op_i,
  input  logic [NUM_REQ-1:0][14:0]             flags_i,
  output logic [NUM_REQ-1:0]                   rvalid_o,
  output logic [31:0]                          result_o,
  output logic [5:0]                           rflags_o,
  output logic                                 acc_req_o,
  input  logic                                 acc_gnt_i,
  output logic [2:0][31:0]                     acc_operands_o,
  output logic [5:0]                           acc_op_o,
  output logic [14:0]                          acc_flags_o,
  input  logic                                 acc_rvalid_i,
  input  logic [31:0]                          acc_result_i,
  input  logic [5:0]                           acc_flags_i,
  output logic                                 err_o,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_q, lock_q, sel, sel_rr, cand;
  logic [IDW-1:0]       fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        count_q;
  logic                 full, found, areq, issue, pop, drop_err, rsp_err;
  logic [NUM_REQ-1:0]   rvalid_d, rvalid_q;
  logic [31:0]          result_q;
  logic [5:0]           rflags_q;
  logic                 err_q;

  assign full = (count_q == FULL_CNT);

  always_comb begin
    found  = 1'b0;
    sel_rr = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        sel_rr = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel      = sel_rr;
    areq     = 1'b0;
    drop_err = 1'b0;
    case (state_q)
      IDLE: begin
        areq = found & ~full;
        if (areq && !acc_gnt_i) state_d = LOCKED;
      end
      LOCKED: begin
        // Selection frozen until the accelerator takes the request.
        sel  = lock_q;
        areq = req_i[lock_q];
        if (!req_i[lock_q]) begin
          drop_err = 1'b1;
          state_d  = IDLE;
        end else if (acc_gnt_i) begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Keep the request low while reset is held so nothing can issue into a flushed FIFO.
  assign acc_req_o      = areq & rst_ni;
  assign issue          = acc_req_o & acc_gnt_i;
  assign acc_operands_o = operands_i[sel];
  assign acc_op_o       = op_i[sel];
  assign acc_flags_o    = flags_i[sel];

  always_comb begin
    gnt_o = '0;
    if (issue) gnt_o[sel] = 1'b1;
  end

  assign pop     = acc_rvalid_i & (count_q != '0);
  assign rsp_err = acc_rvalid_i & (count_q == '0);

  always_comb begin
    rvalid_d = '0;
    if (pop) rvalid_d[fifo_q[rd_q]] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (issue) fifo_q[wr_q] <= sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      lock_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      rvalid_q <= '0;
      result_q <= '0;
      rflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_q | drop_err | rsp_err;
      count_q  <= count_q + CW'(issue) - CW'(pop);
      if (state_q == IDLE && state_d == LOCKED) lock_q <= sel;
      if (issue) begin
        wr_q <= wr_q + 1'b1;
        rr_q <= (sel == LAST_ID) ? '0 : sel + 1'b1;
      end
      if (pop) begin
        rd_q     <= rd_q + 1'b1;
        result_q <= acc_result_i;
        rflags_q <= acc_flags_i;
      end
    end
  end

  assign rvalid_o      = rvalid_q;
  assign result_o      = result_q;
  assign rflags_o      = rflags_q;
  assign err_o         = err_q;
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_apu_share_arbiter.sv
// Bench for apu_share_arbiter (2 cores, 4 outstanding): vector table plus error/reset sequences,
// with a response scoreboard fed by the issued-ID order.
module tb_apu_share_arbiter;
  localparam int NR = 2;
  localparam int MO = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [NR-1:0]            req_i, gnt_o, rvalid_o;
  logic [NR-1:0][2:0][31:0] operands_i;
  logic [NR-1:0][5:0]       op_i;
  logic [NR-1:0][14:0]      flags_i;
  logic [31:0]              result_o, acc_result_i;
  logic [5:0]               rflags_o, acc_op_o, acc_flags_i;
  logic                     acc_req_o, acc_gnt_i, acc_rvalid_i, err_o;
  logic [2:0][31:0]         acc_operands_o;
  logic [14:0]              acc_flags_o;
  logic [2:0]               outstanding_o;

  apu_share_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .operands_i(operands_i), .op_i(op_i), .flags_i(flags_i),
    .rvalid_o(rvalid_o), .result_o(result_o), .rflags_o(rflags_o),
    .acc_req_o(acc_req_o), .acc_gnt_i(acc_gnt_i), .acc_operands_o(acc_operands_o),
    .acc_op_o(acc_op_o), .acc_flags_o(acc_flags_o), .acc_rvalid_i(acc_rvalid_i),
    .acc_result_i(acc_result_i), .acc_flags_i(acc_flags_i), .err_o(err_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] res;
    int          core;     // expected selected core, -1 when acc_req_o must be low
    logic [1:0]  exp_gnt;
    int          exp_out;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [5:0]  fl;
  } rsp_t;

  vec_t        tbl[$];
  rsp_t        rsp_q[$];
  int          iss_q[$];
  logic [31:0] last_res = 32'h0;
  logic [5:0]  last_fl  = 6'h0;
  logic [5:0]  op_c [NR];
  logic [14:0] fl_c [NR];
  int          checks   = 0;
  int          failures = 0;

  function automatic vec_t v(logic [1:0] rq, logic g, logic rv, logic [31:0] res,
                             int core, logic [1:0] eg, int eo);
    vec_t t;
    t.req = rq; t.gnt = g; t.rv = rv; t.res = res; t.core = core; t.exp_gnt = eg; t.exp_out = eo;
    return t;
  endfunction

  function automatic logic [31:0] opnd(int c, int k);
    return 32'(32'h1000_0000 * (k + 1) + c);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_check();
    rsp_t       r;
    logic [1:0] exp_rv;
    exp_rv = 2'b00;
    if (rsp_q.size() > 0) begin
      r        = rsp_q.pop_front();
      exp_rv   = 2'(1 << r.id);
      last_res = r.res;
      last_fl  = r.fl;
    end
    chk("rvalid", 128'(rvalid_o), 128'(exp_rv));
    chk("result", 128'(result_o), 128'(last_res));
    chk("rflags", 128'(rflags_o), 128'(last_fl));
  endtask

  task automatic do_cycle(input logic [1:0] rq, input logic g, input logic rv, input logic [31:0] res,
                          input int core, input logic [1:0] eg, input int eo);
    @(posedge clk_i);
    #1;
    req_i = rq; acc_gnt_i = g; acc_rvalid_i = rv;
    acc_result_i = res; acc_flags_i = res[5:0] ^ 6'h2D;
    @(negedge clk_i);
    sb_check();
    chk("gnt", 128'(gnt_o), 128'(eg));
    chk("acc_req", 128'(acc_req_o), 128'(core >= 0));
    if (core >= 0) begin
      chk("acc_op", 128'(acc_op_o), 128'(op_c[core]));
      chk("acc_flags", 128'(acc_flags_o), 128'(fl_c[core]));
      chk("acc_operands", 128'(acc_operands_o), 128'({opnd(core, 2), opnd(core, 1), opnd(core, 0)}));
    end
    if (eo >= 0) chk("outstanding", 128'(outstanding_o), 128'(eo));
    if (rv && iss_q.size() > 0) begin
      rsp_t r;
      r.id = iss_q.pop_front(); r.res = res; r.fl = res[5:0] ^ 6'h2D;
      rsp_q.push_back(r);
    end
    if (eg != 2'b00) iss_q.push_back(eg[1] ? 1 : 0);
  endtask

  task automatic clear_model();
    rsp_q.delete(); iss_q.delete();
    last_res = 32'h0; last_fl = 6'h0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0; acc_gnt_i = 1'b0; acc_rvalid_i = 1'b0;
    clear_model();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    op_c[0] = 6'h05;    op_c[1] = 6'h2A;
    fl_c[0] = 15'h1234; fl_c[1] = 15'h4321;
    for (int c = 0; c < NR; c++) begin
      op_i[c] = op_c[c]; flags_i[c] = fl_c[c];
      for (int k = 0; k < 3; k++) operands_i[c][k] = opnd(c, k);
    end
    req_i = '0; acc_gnt_i = 1'b0; acc_rvalid_i = 1'b0; acc_result_i = '0; acc_flags_i = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_gnt", 128'(gnt_o), 128'(0));
    chk("rst_rvalid", 128'(rvalid_o), 128'(0));
    chk("rst_acc_req", 128'(acc_req_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_outstanding", 128'(outstanding_o), 128'(0));
    chk("rst_result", 128'({rflags_o, result_o}), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Round robin into full, drain, single core, then lock.
    tbl.push_back(v(2'b11, 1'b1, 1'b0, 32'h0,        0, 2'b01, 0));
    tbl.push_back(v(2'b11, 1'b1, 1'b0, 32'h0,        1, 2'b10, 1));
    tbl.push_back(v(2'b11, 1'b1, 1'b0, 32'h0,        0, 2'b01, 2));
    tbl.push_back(v(2'b11, 1'b1, 1'b0, 32'h0,        1, 2'b10, 3));
    tbl.push_back(v(2'b11, 1'b1, 1'b1, 32'hA000_0001,-1, 2'b00, 4));
    tbl.push_back(v(2'b11, 1'b1, 1'b1, 32'hA000_0012, 0, 2'b01, 3));
    tbl.push_back(v(2'b00, 1'b0, 1'b1, 32'hA000_0023,-1, 2'b00, 3));
    tbl.push_back(v(2'b00, 1'b0, 1'b1, 32'hA000_0034,-1, 2'b00, 2));
    tbl.push_back(v(2'b00, 1'b0, 1'b1, 32'hA000_0045,-1, 2'b00, 1));
    tbl.push_back(v(2'b00, 1'b0, 1'b0, 32'h0,       -1, 2'b00, 0));
    tbl.push_back(v(2'b01, 1'b1, 1'b0, 32'h0,        0, 2'b01, 0));
    tbl.push_back(v(2'b00, 1'b0, 1'b0, 32'h0,       -1, 2'b00, 1));
    tbl.push_back(v(2'b00, 1'b0, 1'b1, 32'hDEADBEEF,-1, 2'b00, 1));
    tbl.push_back(v(2'b00, 1'b0, 1'b0, 32'h0,       -1, 2'b00, 0));
    tbl.push_back(v(2'b10, 1'b1, 1'b0, 32'h0,        1, 2'b10, 0));
    tbl.push_back(v(2'b10, 1'b0, 1'b0, 32'h0,        1, 2'b00, 1));
    tbl.push_back(v(2'b11, 1'b0, 1'b0, 32'h0,        1, 2'b00, 1));
    tbl.push_back(v(2'b11, 1'b0, 1'b0, 32'h0,        1, 2'b00, 1));
    tbl.push_back(v(2'b11, 1'b1, 1'b0, 32'h0,        1, 2'b10, 1));
    tbl.push_back(v(2'b01, 1'b1, 1'b0, 32'h0,        0, 2'b01, 2));
    tbl.push_back(v(2'b00, 1'b0, 1'b1, 32'h5555_0101,-1, 2'b00, 3));
    tbl.push_back(v(2'b00, 1'b0, 1'b1, 32'h5555_0202,-1, 2'b00, 2));
    tbl.push_back(v(2'b00, 1'b0, 1'b1, 32'h5555_0303,-1, 2'b00, 1));
    tbl.push_back(v(2'b00, 1'b0, 1'b0, 32'h0,       -1, 2'b00, 0));
    foreach (tbl[i])
      do_cycle(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].res, tbl[i].core, tbl[i].exp_gnt, tbl[i].exp_out);
    chk("err_clean", 128'(err_o), 128'(0));

    // Response with nothing outstanding: dropped, error, result held.
    do_cycle(2'b00, 1'b0, 1'b1, 32'h1111_2222, -1, 2'b00, 0);
    do_cycle(2'b00, 1'b0, 1'b0, 32'h0,         -1, 2'b00, 0);
    chk("err_empty_rsp", 128'(err_o), 128'(1));

    do_reset();
    chk("err_after_reset", 128'(err_o), 128'(0));

    // Locked core drops its request: error, back to IDLE, nothing issued.
    do_cycle(2'b01, 1'b0, 1'b0, 32'h0,  0, 2'b00, 0);
    do_cycle(2'b00, 1'b0, 1'b0, 32'h0, -1, 2'b00, 0);
    do_cycle(2'b10, 1'b0, 1'b0, 32'h0,  1, 2'b00, 0);
    chk("err_lock_drop", 128'(err_o), 128'(1));

    // Reset with two results in flight.
    do_reset();
    do_cycle(2'b01, 1'b1, 1'b0, 32'h0,         0, 2'b01, 0);
    do_cycle(2'b10, 1'b1, 1'b0, 32'h0,         1, 2'b10, 1);
    do_cycle(2'b01, 1'b1, 1'b0, 32'h0,         0, 2'b01, 2);
    do_cycle(2'b00, 1'b0, 1'b1, 32'hCAFE_F00D, -1, 2'b00, 3);
    do_cycle(2'b00, 1'b0, 1'b0, 32'h0,         -1, 2'b00, 2);
    @(posedge clk_i);
    #2;
    req_i = 2'b11; acc_gnt_i = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    chk("flight_gnt", 128'(gnt_o), 128'(0));
    chk("flight_acc_req", 128'(acc_req_o), 128'(0));
    chk("flight_rvalid", 128'(rvalid_o), 128'(0));
    chk("flight_result", 128'({rflags_o, result_o}), 128'(0));
    chk("flight_err", 128'(err_o), 128'(0));
    chk("flight_outstanding", 128'(outstanding_o), 128'(0));
    @(negedge clk_i);
    req_i = '0; acc_gnt_i = 1'b0;
    clear_model();
    rst_ni = 1'b1;
    do_cycle(2'b11, 1'b1, 1'b0, 32'h0, 0, 2'b01, 0);
    do_cycle(2'b00, 1'b0, 1'b0, 32'h0, -1, 2'b00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
